// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: captures execute results for the memory stage,
// handles stall/flush, forwards writeback data into store data, counts commits.
module ex_mem_register #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  input  logic [DATA_W-1:0]     ex_alu_result_i,
  input  logic [DATA_W-1:0]     ex_store_data_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_reg_i,
  input  logic                  ex_mem_write_i,
  input  logic                  ex_mem_to_reg_i,
  input  logic                  ex_reg_write_i,
  input  logic                  wb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_dest_reg_i,
  input  logic [DATA_W-1:0]     wb_write_data_i,
  output logic                  mem_valid_o,
  output logic [DATA_W-1:0]     mem_address_o,
  output logic [DATA_W-1:0]     mem_write_data_o,
  output logic                  mem_write_en_o,
  output logic [REG_ADDR_W-1:0] mem_dest_reg_o,
  output logic                  mem_reg_write_o,
  output logic                  mem_mem_to_reg_o,
  output logic [15:0]           store_count_o
);

  logic                  valid_q,      valid_d;
  logic [DATA_W-1:0]     aluResult_q,  aluResult_d;
  logic [DATA_W-1:0]     storeData_q,  storeData_d;
  logic [REG_ADDR_W-1:0] rtAddr_q,     rtAddr_d;
  logic [REG_ADDR_W-1:0] destReg_q,    destReg_d;
  logic                  memWrite_q,   memWrite_d;
  logic                  memToReg_q,   memToReg_d;
  logic                  regWrite_q,   regWrite_d;
  logic [15:0]           storeCount_q, storeCount_d;

  logic fwdEx;
  logic fwdHeld;
  logic commit;

  // Register 0 is hard-wired zero, so a WB write to it never forwards.
  assign fwdEx   = wb_reg_write_i && (wb_dest_reg_i == ex_rt_addr_i) && (ex_rt_addr_i != '0);
  assign fwdHeld = wb_reg_write_i && (wb_dest_reg_i == rtAddr_q) && (rtAddr_q != '0);
  assign commit  = mem_write_en_o && !stall_i;

  always_comb begin
    valid_d     = valid_q;
    aluResult_d = aluResult_q;
    storeData_d = storeData_q;
    rtAddr_d    = rtAddr_q;
    destReg_d   = destReg_q;
    memWrite_d  = memWrite_q;
    memToReg_d  = memToReg_q;
    regWrite_d  = regWrite_q;

    if (flush_i) begin
      valid_d     = 1'b0;
      aluResult_d = '0;
      storeData_d = '0;
      rtAddr_d    = '0;
      destReg_d   = '0;
      memWrite_d  = 1'b0;
      memToReg_d  = 1'b0;
      regWrite_d  = 1'b0;
    end else if (stall_i) begin
      if (fwdHeld) begin
        storeData_d = wb_write_data_i;
      end
    end else begin
      valid_d     = ex_valid_i;
      aluResult_d = ex_alu_result_i;
      storeData_d = fwdEx ? wb_write_data_i : ex_store_data_i;
      rtAddr_d    = ex_rt_addr_i;
      destReg_d   = ex_dest_reg_i;
      memWrite_d  = ex_mem_write_i  && ex_valid_i;
      memToReg_d  = ex_mem_to_reg_i && ex_valid_i;
      regWrite_d  = ex_reg_write_i  && ex_valid_i;
    end
  end

  // A flushed store still counts if it was not stalled: its write completes on that edge.
  always_comb begin
    storeCount_d = storeCount_q;
    if (commit && (storeCount_q != 16'hFFFF)) begin
      storeCount_d = storeCount_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      aluResult_q  <= '0;
      storeData_q  <= '0;
      rtAddr_q     <= '0;
      destReg_q    <= '0;
      memWrite_q   <= 1'b0;
      memToReg_q   <= 1'b0;
      regWrite_q   <= 1'b0;
      storeCount_q <= '0;
    end else begin
      valid_q      <= valid_d;
      aluResult_q  <= aluResult_d;
      storeData_q  <= storeData_d;
      rtAddr_q     <= rtAddr_d;
      destReg_q    <= destReg_d;
      memWrite_q   <= memWrite_d;
      memToReg_q   <= memToReg_d;
      regWrite_q   <= regWrite_d;
      storeCount_q <= storeCount_d;
    end
  end

  assign mem_valid_o      = valid_q;
  assign mem_address_o    = aluResult_q;
  assign mem_write_data_o = storeData_q;
  assign mem_write_en_o   = valid_q && memWrite_q;
  assign mem_dest_reg_o   = destReg_q;
  assign mem_reg_write_o  = valid_q && regWrite_q;
  assign mem_mem_to_reg_o = valid_q && memToReg_q;
  assign store_count_o    = storeCount_q;

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed bench for ex_mem_register: vector table plus hand sequences for
// reset, hold forwarding, reset during stall and counter saturation.
module tb_ex_mem_register;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i, flush_i, ex_valid_i;
  logic [15:0] ex_alu_result_i, ex_store_data_i;
  logic [2:0]  ex_rt_addr_i, ex_dest_reg_i;
  logic        ex_mem_write_i, ex_mem_to_reg_i, ex_reg_write_i;
  logic        wb_reg_write_i;
  logic [2:0]  wb_dest_reg_i;
  logic [15:0] wb_write_data_i;
  logic        mem_valid_o, mem_write_en_o, mem_reg_write_o, mem_mem_to_reg_o;
  logic [15:0] mem_address_o, mem_write_data_o, store_count_o;
  logic [2:0]  mem_dest_reg_o;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        stall, flush, exValid;
    logic [15:0] alu, sd;
    logic [2:0]  rt, dest;
    logic        mw, m2r, rw, wbRw;
    logic [2:0]  wbDest;
    logic [15:0] wbData;
    logic        eValid;
    logic [15:0] eAddr, eWdata;
    logic        eWe;
    logic [2:0]  eDest;
    logic        eRw, eM2r;
    logic [15:0] eCount;
  } vec_t;

  vec_t vecs[12];

  ex_mem_register #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .ex_valid_i       (ex_valid_i),
    .ex_alu_result_i  (ex_alu_result_i),
    .ex_store_data_i  (ex_store_data_i),
    .ex_rt_addr_i     (ex_rt_addr_i),
    .ex_dest_reg_i    (ex_dest_reg_i),
    .ex_mem_write_i   (ex_mem_write_i),
    .ex_mem_to_reg_i  (ex_mem_to_reg_i),
    .ex_reg_write_i   (ex_reg_write_i),
    .wb_reg_write_i   (wb_reg_write_i),
    .wb_dest_reg_i    (wb_dest_reg_i),
    .wb_write_data_i  (wb_write_data_i),
    .mem_valid_o      (mem_valid_o),
    .mem_address_o    (mem_address_o),
    .mem_write_data_o (mem_write_data_o),
    .mem_write_en_o   (mem_write_en_o),
    .mem_dest_reg_o   (mem_dest_reg_o),
    .mem_reg_write_o  (mem_reg_write_o),
    .mem_mem_to_reg_o (mem_mem_to_reg_o),
    .store_count_o    (store_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    stall_i         = v.stall;
    flush_i         = v.flush;
    ex_valid_i      = v.exValid;
    ex_alu_result_i = v.alu;
    ex_store_data_i = v.sd;
    ex_rt_addr_i    = v.rt;
    ex_dest_reg_i   = v.dest;
    ex_mem_write_i  = v.mw;
    ex_mem_to_reg_i = v.m2r;
    ex_reg_write_i  = v.rw;
    wb_reg_write_i  = v.wbRw;
    wb_dest_reg_i   = v.wbDest;
    wb_write_data_i = v.wbData;
  endtask

  task automatic clearInputs();
    stall_i = 1'b0; flush_i = 1'b0; ex_valid_i = 1'b0;
    ex_alu_result_i = 16'h0; ex_store_data_i = 16'h0;
    ex_rt_addr_i = 3'd0; ex_dest_reg_i = 3'd0;
    ex_mem_write_i = 1'b0; ex_mem_to_reg_i = 1'b0; ex_reg_write_i = 1'b0;
    wb_reg_write_i = 1'b0; wb_dest_reg_i = 3'd0; wb_write_data_i = 16'h0;
  endtask

  task automatic driveStore(input logic [15:0] addr, input logic [15:0] data, input logic [2:0] rt);
    clearInputs();
    ex_valid_i = 1'b1; ex_mem_write_i = 1'b1;
    ex_alu_result_i = addr; ex_store_data_i = data; ex_rt_addr_i = rt;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"}, {15'd0, mem_valid_o}, 16'h0);
    checkOutput({tag, " addr"},  mem_address_o, 16'h0);
    checkOutput({tag, " wdata"}, mem_write_data_o, 16'h0);
    checkOutput({tag, " we"},    {15'd0, mem_write_en_o}, 16'h0);
    checkOutput({tag, " rw"},    {15'd0, mem_reg_write_o}, 16'h0);
    checkOutput({tag, " count"}, store_count_o, 16'h0);
  endtask

  task automatic doReset();
    @(negedge clk_i);
    clearInputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    // Fields: stall flush exValid alu sd rt dest mw m2r rw | wbRw wbDest wbData | expected valid addr wdata we dest rw m2r count
    vecs[0]  = '{1'b0,1'b0,1'b1,16'h1234,16'h0AAA,3'd3,3'd0,1'b1,1'b0,1'b0, 1'b1,3'd3,16'h5555, 1'b1,16'h1234,16'h5555,1'b1,3'd0,1'b0,1'b0,16'd0};
    vecs[1]  = '{1'b0,1'b0,1'b1,16'h2000,16'h0AAA,3'd0,3'd0,1'b1,1'b0,1'b0, 1'b1,3'd0,16'h5555, 1'b1,16'h2000,16'h0AAA,1'b1,3'd0,1'b0,1'b0,16'd1};
    vecs[2]  = '{1'b0,1'b0,1'b1,16'h0040,16'h1111,3'd2,3'd4,1'b0,1'b1,1'b1, 1'b0,3'd2,16'h9999, 1'b1,16'h0040,16'h1111,1'b0,3'd4,1'b1,1'b1,16'd2};
    vecs[3]  = '{1'b0,1'b0,1'b0,16'h0077,16'h0123,3'd1,3'd0,1'b1,1'b1,1'b1, 1'b1,3'd1,16'h4321, 1'b0,16'h0077,16'h4321,1'b0,3'd0,1'b0,1'b0,16'd2};
    vecs[4]  = '{1'b0,1'b0,1'b1,16'h00FF,16'h0000,3'd6,3'd6,1'b0,1'b0,1'b1, 1'b1,3'd6,16'hAAAA, 1'b1,16'h00FF,16'hAAAA,1'b0,3'd6,1'b1,1'b0,16'd2};
    vecs[5]  = '{1'b0,1'b0,1'b1,16'h3000,16'h0BBB,3'd7,3'd0,1'b1,1'b0,1'b0, 1'b0,3'd7,16'hCCCC, 1'b1,16'h3000,16'h0BBB,1'b1,3'd0,1'b0,1'b0,16'd2};
    vecs[6]  = '{1'b1,1'b0,1'b1,16'h9999,16'h0FFF,3'd2,3'd3,1'b0,1'b1,1'b1, 1'b1,3'd7,16'hDDDD, 1'b1,16'h3000,16'hDDDD,1'b1,3'd0,1'b0,1'b0,16'd2};
    vecs[7]  = '{1'b1,1'b0,1'b1,16'h9999,16'h0FFF,3'd7,3'd3,1'b0,1'b1,1'b1, 1'b0,3'd7,16'hEEEE, 1'b1,16'h3000,16'hDDDD,1'b1,3'd0,1'b0,1'b0,16'd2};
    vecs[8]  = '{1'b1,1'b1,1'b1,16'h8888,16'h0888,3'd1,3'd2,1'b1,1'b0,1'b0, 1'b1,3'd1,16'h7777, 1'b0,16'h0000,16'h0000,1'b0,3'd0,1'b0,1'b0,16'd2};
    vecs[9]  = '{1'b0,1'b0,1'b1,16'h4000,16'h0E0E,3'd1,3'd0,1'b1,1'b0,1'b0, 1'b1,3'd2,16'h1212, 1'b1,16'h4000,16'h0E0E,1'b1,3'd0,1'b0,1'b0,16'd2};
    vecs[10] = '{1'b0,1'b1,1'b1,16'h5555,16'h0555,3'd3,3'd3,1'b1,1'b1,1'b1, 1'b1,3'd3,16'h3333, 1'b0,16'h0000,16'h0000,1'b0,3'd0,1'b0,1'b0,16'd3};
    vecs[11] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,3'd0,3'd0,1'b0,1'b0,1'b0, 1'b0,3'd0,16'h0000, 1'b0,16'h0000,16'h0000,1'b0,3'd0,1'b0,1'b0,16'd3};

    clearInputs();
    rst_ni = 1'b0;
    #12 rst_ni = 1'b1;

    // Asynchronous reset with a live store registered and nonzero inputs.
    @(negedge clk_i);
    driveStore(16'hABCD, 16'h0F0F, 3'd2);
    ex_reg_write_i = 1'b1; ex_mem_to_reg_i = 1'b1; ex_dest_reg_i = 3'd7;
    wb_reg_write_i = 1'b1; wb_dest_reg_i = 3'd4; wb_write_data_i = 16'h1111;
    @(posedge clk_i); #1;
    checkOutput("pre-reset we", {15'd0, mem_write_en_o}, 16'h1);
    @(negedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    checkAllZero("async reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    driveStore(16'h1234, 16'h0000, 3'd0);
    @(posedge clk_i); #1;
    checkOutput("post-reset addr", mem_address_o, 16'h1234);
    checkOutput("post-reset we", {15'd0, mem_write_en_o}, 16'h1);

    doReset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      applyStimulus(vecs[i]);
      @(posedge clk_i); #1;
      checkOutput($sformatf("vec%0d valid", i), {15'd0, mem_valid_o}, {15'd0, vecs[i].eValid});
      checkOutput($sformatf("vec%0d addr", i), mem_address_o, vecs[i].eAddr);
      checkOutput($sformatf("vec%0d wdata", i), mem_write_data_o, vecs[i].eWdata);
      checkOutput($sformatf("vec%0d we", i), {15'd0, mem_write_en_o}, {15'd0, vecs[i].eWe});
      checkOutput($sformatf("vec%0d dest", i), {13'd0, mem_dest_reg_o}, {13'd0, vecs[i].eDest});
      checkOutput($sformatf("vec%0d rw", i), {15'd0, mem_reg_write_o}, {15'd0, vecs[i].eRw});
      checkOutput($sformatf("vec%0d m2r", i), {15'd0, mem_mem_to_reg_o}, {15'd0, vecs[i].eM2r});
      checkOutput($sformatf("vec%0d count", i), store_count_o, vecs[i].eCount);
    end

    // Store held three stall cycles; WB writes its rt in the middle one.
    doReset();
    @(negedge clk_i);
    driveStore(16'h5000, 16'h0111, 3'd5);
    @(posedge clk_i); #1;
    checkOutput("hold capture wdata", mem_write_data_o, 16'h0111);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      clearInputs();
      stall_i = 1'b1;
      ex_valid_i = 1'b1; ex_alu_result_i = 16'hFFFF; ex_store_data_i = 16'h2222;
      if (c == 1) begin
        wb_reg_write_i = 1'b1; wb_dest_reg_i = 3'd5; wb_write_data_i = 16'hBEEF;
      end
      @(posedge clk_i); #1;
      checkOutput($sformatf("hold%0d addr", c), mem_address_o, 16'h5000);
      checkOutput($sformatf("hold%0d wdata", c), mem_write_data_o, (c == 0) ? 16'h0111 : 16'hBEEF);
      checkOutput($sformatf("hold%0d we", c), {15'd0, mem_write_en_o}, 16'h1);
      checkOutput($sformatf("hold%0d count", c), store_count_o, 16'h0);
    end
    @(negedge clk_i);
    clearInputs();
    @(posedge clk_i); #1;
    checkOutput("hold release count", store_count_o, 16'h1);
    checkOutput("hold release we", {15'd0, mem_write_en_o}, 16'h0);

    // Reset landing mid-stall discards the held store.
    doReset();
    @(negedge clk_i);
    driveStore(16'h6000, 16'h0666, 3'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    stall_i = 1'b1;
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    checkAllZero("stall reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    clearInputs();
    @(posedge clk_i); #1;
    checkOutput("stall reset after we", {15'd0, mem_write_en_o}, 16'h0);
    checkOutput("stall reset after count", store_count_o, 16'h0);

    // Back-to-back stores: commit k lands on edge k+1.
    doReset();
    for (int n = 1; n <= 65538; n++) begin
      @(negedge clk_i);
      driveStore(n[15:0], 16'h0001, 3'd0);
      @(posedge clk_i); #1;
      if (n == 65535) checkOutput("sat FFFE", store_count_o, 16'hFFFE);
      if (n == 65536) checkOutput("sat FFFF", store_count_o, 16'hFFFF);
    end
    @(negedge clk_i);
    clearInputs();
    @(posedge clk_i); #1;
    checkOutput("sat hold", store_count_o, 16'hFFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
